// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared encodings for the multi-cycle MIPS controller: opcode/funct values,
// FSM state codes, instruction classes and datapath select encodings.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Opcode field values (MIPS-I)
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Funct field values for R-type
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // FSM state encoding
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  // Instruction classes: they decide the path taken after DECODE
  localparam logic [2:0] CLS_ALU = 3'd0;  // register/immediate ALU op, ends in WB
  localparam logic [2:0] CLS_LW  = 3'd1;
  localparam logic [2:0] CLS_SW  = 3'd2;
  localparam logic [2:0] CLS_BEQ = 3'd3;
  localparam logic [2:0] CLS_BNE = 3'd4;
  localparam logic [2:0] CLS_J   = 3'd5;
  localparam logic [2:0] CLS_JR  = 3'd6;
  localparam logic [2:0] CLS_JAL = 3'd7;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  // Immediate extension select
  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  // Destination register select
  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  // Next-PC select
  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl_dec
// Purely combinational instruction-class decode. Produces the legality flag,
// the instruction class and the datapath selects for the instruction in IR.
// Illegal encodings leave every select at zero.
// Optional: MC_CTRL_EXT_EN adds addiu and bne to the legal set.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       legal,
  output logic [2:0] cls,
  output logic [1:0] aluop,
  output logic [1:0] extop,
  output logic [1:0] regdst,
  output logic       alusrc,
  output logic       memtoreg
);

  // Map opcode/funct to class and selects; unknown encodings stay illegal
  always_comb begin
    legal    = 1'b0;
    cls      = CLS_ALU;
    aluop    = ALU_ADD;
    extop    = EXT_ZERO;
    regdst   = RD_RT;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: begin
            legal  = 1'b1;
            regdst = RD_RD;
          end
          FN_SUBU: begin
            legal  = 1'b1;
            aluop  = ALU_SUB;
            regdst = RD_RD;
          end
          FN_JR: begin
            legal = 1'b1;
            cls   = CLS_JR;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        legal  = 1'b1;
        aluop  = ALU_OR;
        alusrc = 1'b1;
      end
      OP_LUI: begin
        legal  = 1'b1;
        aluop  = ALU_OR;
        extop  = EXT_UPPER;
        alusrc = 1'b1;
      end
      OP_LW: begin
        legal    = 1'b1;
        cls      = CLS_LW;
        extop    = EXT_SIGN;
        alusrc   = 1'b1;
        memtoreg = 1'b1;
      end
      OP_SW: begin
        legal  = 1'b1;
        cls    = CLS_SW;
        extop  = EXT_SIGN;
        alusrc = 1'b1;
      end
      // Branch compares by subtraction; offset is sign-extended
      OP_BEQ: begin
        legal = 1'b1;
        cls   = CLS_BEQ;
        aluop = ALU_SUB;
        extop = EXT_SIGN;
      end
      OP_J: begin
        legal = 1'b1;
        cls   = CLS_J;
      end
      OP_JAL: begin
        legal  = 1'b1;
        cls    = CLS_JAL;
        regdst = RD_R31;
      end
`ifdef MC_CTRL_EXT_EN
      OP_ADDIU: begin
        legal  = 1'b1;
        extop  = EXT_SIGN;
        alusrc = 1'b1;
      end
      OP_BNE: begin
        legal = 1'b1;
        cls   = CLS_BNE;
        aluop = ALU_SUB;
        extop = EXT_SIGN;
      end
`else
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with a latency
// counter that stretches FETCH and MEM to MEM_LAT cycles each.
// Optional: MC_CTRL_EXT_EN enables addiu and bne (decoded in mc_ctrl_dec).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_we,
  output logic       alusrc,
  output logic       memtoreg,
  output logic       illegal,
  output logic [1:0] aluop,
  output logic [1:0] extop,
  output logic [1:0] regdst,
  output logic [1:0] npc_sel,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             lat_done;

  logic             dec_legal;
  logic [2:0]       dec_cls;
  logic [1:0]       dec_aluop;
  logic [1:0]       dec_extop;
  logic [1:0]       dec_regdst;
  logic             dec_alusrc;
  logic             dec_memtoreg;

  mc_ctrl_dec u_dec (
    .op       (op),
    .func     (func),
    .legal    (dec_legal),
    .cls      (dec_cls),
    .aluop    (dec_aluop),
    .extop    (dec_extop),
    .regdst   (dec_regdst),
    .alusrc   (dec_alusrc),
    .memtoreg (dec_memtoreg)
  );

  // Last cycle of a FETCH or MEM access
  assign lat_done = (cnt_q == LAST_CNT);
  assign state    = state_q;

  // State and latency counter registers; reset aborts any instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; counter only advances inside FETCH/MEM and clears otherwise
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_FETCH: begin
        if (lat_done) state_d = ST_DECODE;
        else          cnt_d   = cnt_q + CNT_ONE;
      end
      ST_DECODE: begin
        state_d = dec_legal ? ST_EXEC : ST_FETCH;
      end
      ST_EXEC: begin
        case (dec_cls)
          CLS_ALU, CLS_JAL: state_d = ST_WB;
          CLS_LW, CLS_SW:   state_d = ST_MEM;
          default:          state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (lat_done) state_d = (dec_cls == CLS_LW) ? ST_WB : ST_FETCH;
        else          cnt_d   = cnt_q + CNT_ONE;
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs: all forced low while reset is asserted; selects only after FETCH
  always_comb begin
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    illegal  = 1'b0;
    npc_sel  = NPC_PC4;
    aluop    = ALU_ADD;
    extop    = EXT_ZERO;
    regdst   = RD_RT;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          if (lat_done) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        ST_DECODE: illegal = ~dec_legal;
        ST_EXEC: begin
          case (dec_cls)
            CLS_BEQ: begin
              pc_we   = zero;
              npc_sel = NPC_BR;
            end
            CLS_BNE: begin
              pc_we   = ~zero;
              npc_sel = NPC_BR;
            end
            CLS_J, CLS_JAL: begin
              pc_we   = 1'b1;
              npc_sel = NPC_JUMP;
            end
            CLS_JR: begin
              pc_we   = 1'b1;
              npc_sel = NPC_JR;
            end
            default: ;
          endcase
        end
        ST_MEM:  mem_we = (dec_cls == CLS_SW);
        ST_WB:   reg_we = 1'b1;
        default: ;
      endcase
      // IR is stable from DECODE onward, so decoded selects stay constant
      if (state_q != ST_FETCH) begin
        aluop    = dec_aluop;
        extop    = dec_extop;
        regdst   = dec_regdst;
        alusrc   = dec_alusrc;
        memtoreg = dec_memtoreg;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mc_ctrl
// Directed bench for mc_ctrl. Three instances run with MEM_LAT = 1, 2, 3.
// Each table record executes one instruction from a fresh reset and checks
// cycle count, enable timing, EXEC next-PC select and datapath selects.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

  logic       clk;
  logic [2:0] rst_v;
  logic [5:0] op_v   [3];
  logic [5:0] func_v [3];
  logic [2:0] zero_v;
  logic [2:0] pc_we_v, ir_we_v, reg_we_v, mem_we_v, alusrc_v, memtoreg_v, illegal_v;
  logic [1:0] aluop_v [3];
  logic [1:0] extop_v [3];
  logic [1:0] regdst_v [3];
  logic [1:0] npc_v [3];
  logic [2:0] state_v [3];

  int checks;
  int errors;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mc_ctrl #(.MEM_LAT(g + 1), .CNT_W(4)) u_dut (
      .clk      (clk),
      .reset    (rst_v[g]),
      .op       (op_v[g]),
      .func     (func_v[g]),
      .zero     (zero_v[g]),
      .pc_we    (pc_we_v[g]),
      .ir_we    (ir_we_v[g]),
      .reg_we   (reg_we_v[g]),
      .mem_we   (mem_we_v[g]),
      .alusrc   (alusrc_v[g]),
      .memtoreg (memtoreg_v[g]),
      .illegal  (illegal_v[g]),
      .aluop    (aluop_v[g]),
      .extop    (extop_v[g]),
      .regdst   (regdst_v[g]),
      .npc_sel  (npc_v[g]),
      .state    (state_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         d;        // instance index: MEM_LAT = d + 1
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    int         cycles;
    int         irwe_at;
    int         regwe_at; // 0 = never
    int         memwe_n;
    int         pcwe_n;
    logic [1:0] npc;      // npc_sel seen in EXEC (00 if no EXEC)
    int         ill_n;
    logic [1:0] aluop;
    logic [1:0] extop;
    logic [1:0] regdst;
    logic       alusrc;
    logic       memtoreg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int d, logic [5:0] op, logic [5:0] func, logic zero,
                              int cycles, int irwe_at, int regwe_at, int memwe_n,
                              int pcwe_n, logic [1:0] npc, int ill_n, logic [1:0] aluop,
                              logic [1:0] extop, logic [1:0] regdst, logic alusrc,
                              logic memtoreg);
    vec_t v;
    v.d = d; v.op = op; v.func = func; v.zero = zero; v.cycles = cycles;
    v.irwe_at = irwe_at; v.regwe_at = regwe_at; v.memwe_n = memwe_n;
    v.pcwe_n = pcwe_n; v.npc = npc; v.ill_n = ill_n; v.aluop = aluop;
    v.extop = extop; v.regdst = regdst; v.alusrc = alusrc; v.memtoreg = memtoreg;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] pack(int d);
    return {pc_we_v[d], ir_we_v[d], reg_we_v[d], mem_we_v[d], alusrc_v[d],
            memtoreg_v[d], illegal_v[d], aluop_v[d], extop_v[d], regdst_v[d],
            npc_v[d], state_v[d]};
  endfunction

  // Reset instance d, leave it in its first FETCH cycle (negedge + 1)
  task automatic pulse_reset(input int d);
    rst_v[d] = 1'b1;
    @(posedge clk);
    #1 rst_v[d] = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, irwe_at, regwe_at, memwe_n, pcwe_n, ill_n, sel_bad, clash;
    logic [1:0] npc;
    logic [2:0] prev;
    logic [7:0] exp_sel, got_sel;
    bit done;
    string t;
    cyc = 0; irwe_at = 0; regwe_at = 0; memwe_n = 0; pcwe_n = 0; ill_n = 0;
    sel_bad = 0; clash = 0; npc = 2'b00; prev = 3'd0; done = 1'b0;
    exp_sel = {v.aluop, v.extop, v.regdst, v.alusrc, v.memtoreg};
    op_v[v.d] = v.op; func_v[v.d] = v.func; zero_v[v.d] = v.zero;
    pulse_reset(v.d);
    for (int n = 0; n < 64; n++) begin
      if (n > 0 && state_v[v.d] == 3'd0 && prev != 3'd0) begin
        done = 1'b1;
        break;
      end
      cyc++;
      got_sel = {aluop_v[v.d], extop_v[v.d], regdst_v[v.d], alusrc_v[v.d], memtoreg_v[v.d]};
      if (ir_we_v[v.d] && irwe_at == 0) irwe_at = cyc;
      if (reg_we_v[v.d] && regwe_at == 0) regwe_at = cyc;
      if (mem_we_v[v.d]) memwe_n++;
      if (pc_we_v[v.d]) pcwe_n++;
      if (illegal_v[v.d]) ill_n++;
      if (illegal_v[v.d] && (pc_we_v[v.d] | ir_we_v[v.d] | reg_we_v[v.d] | mem_we_v[v.d])) clash++;
      if (state_v[v.d] == 3'd2) npc = npc_v[v.d];
      if (state_v[v.d] == 3'd0) begin
        if (got_sel != 8'd0) sel_bad++;
      end else if (got_sel != exp_sel) sel_bad++;
      prev = state_v[v.d];
      @(negedge clk);
      #1;
    end
    t = $sformatf("v%0d", idx);
    chk({t, " timeout"}, int'(done), 1);
    chk({t, " cycles"}, cyc, v.cycles);
    chk({t, " ir_we cycle"}, irwe_at, v.irwe_at);
    chk({t, " reg_we cycle"}, regwe_at, v.regwe_at);
    chk({t, " mem_we count"}, memwe_n, v.memwe_n);
    chk({t, " pc_we count"}, pcwe_n, v.pcwe_n);
    chk({t, " exec npc_sel"}, int'(npc), int'(v.npc));
    chk({t, " illegal count"}, ill_n, v.ill_n);
    chk({t, " select errors"}, sel_bad, 0);
    chk({t, " illegal with write"}, clash, 0);
  endtask

  initial begin
    int mem_cnt;
    checks = 0;
    errors = 0;
    rst_v  = 3'b111;
    zero_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      op_v[i]   = 6'h00;
      func_v[i] = 6'h00;
    end

    // d op func z cyc ir rg mw pw npc ill alu ext rdst src m2r
    tbl.push_back(mk(0, 6'h00, 6'h21, 0, 4, 1, 4, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b01, 0, 0)); // addu
    tbl.push_back(mk(0, 6'h00, 6'h23, 0, 4, 1, 4, 0, 1, 2'b00, 0, 2'b01, 2'b00, 2'b01, 0, 0)); // subu
    tbl.push_back(mk(0, 6'h0d, 6'h00, 0, 4, 1, 4, 0, 1, 2'b00, 0, 2'b10, 2'b00, 2'b00, 1, 0)); // ori
    tbl.push_back(mk(0, 6'h0f, 6'h00, 0, 4, 1, 4, 0, 1, 2'b00, 0, 2'b10, 2'b10, 2'b00, 1, 0)); // lui
    tbl.push_back(mk(0, 6'h23, 6'h00, 0, 5, 1, 5, 0, 1, 2'b00, 0, 2'b00, 2'b01, 2'b00, 1, 1)); // lw
    tbl.push_back(mk(0, 6'h2b, 6'h00, 0, 4, 1, 0, 1, 1, 2'b00, 0, 2'b00, 2'b01, 2'b00, 1, 0)); // sw
    tbl.push_back(mk(0, 6'h04, 6'h00, 0, 3, 1, 0, 0, 1, 2'b01, 0, 2'b01, 2'b01, 2'b00, 0, 0)); // beq nt
    tbl.push_back(mk(0, 6'h04, 6'h00, 1, 3, 1, 0, 0, 2, 2'b01, 0, 2'b01, 2'b01, 2'b00, 0, 0)); // beq t
    tbl.push_back(mk(0, 6'h02, 6'h00, 0, 3, 1, 0, 0, 2, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0, 0)); // j
    tbl.push_back(mk(0, 6'h00, 6'h08, 0, 3, 1, 0, 0, 2, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0)); // jr
    tbl.push_back(mk(0, 6'h03, 6'h00, 0, 4, 1, 4, 0, 2, 2'b10, 0, 2'b00, 2'b00, 2'b10, 0, 0)); // jal
    tbl.push_back(mk(0, 6'h3f, 6'h00, 0, 2, 1, 0, 0, 1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0)); // bad op
    tbl.push_back(mk(0, 6'h00, 6'h3f, 0, 2, 1, 0, 0, 1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0)); // bad funct
`ifdef MC_CTRL_EXT_EN
    tbl.push_back(mk(0, 6'h05, 6'h00, 0, 3, 1, 0, 0, 2, 2'b01, 0, 2'b01, 2'b01, 2'b00, 0, 0)); // bne t
    tbl.push_back(mk(0, 6'h05, 6'h00, 1, 3, 1, 0, 0, 1, 2'b01, 0, 2'b01, 2'b01, 2'b00, 0, 0)); // bne nt
    tbl.push_back(mk(0, 6'h09, 6'h00, 0, 4, 1, 4, 0, 1, 2'b00, 0, 2'b00, 2'b01, 2'b00, 1, 0)); // addiu
`else
    tbl.push_back(mk(0, 6'h05, 6'h00, 0, 2, 1, 0, 0, 1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0)); // bne
    tbl.push_back(mk(0, 6'h09, 6'h00, 0, 2, 1, 0, 0, 1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0)); // addiu
`endif
    tbl.push_back(mk(2, 6'h23, 6'h00, 0, 9, 3, 9, 0, 1, 2'b00, 0, 2'b00, 2'b01, 2'b00, 1, 1)); // lw L3
    tbl.push_back(mk(2, 6'h00, 6'h21, 0, 6, 3, 6, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b01, 0, 0)); // addu L3
    tbl.push_back(mk(1, 6'h2b, 6'h00, 0, 6, 2, 0, 2, 1, 2'b00, 0, 2'b00, 2'b01, 2'b00, 1, 0)); // sw L2
    tbl.push_back(mk(1, 6'h04, 6'h00, 1, 4, 2, 0, 0, 2, 2'b01, 0, 2'b01, 2'b01, 2'b00, 0, 0)); // beq L2

    // Reset state: outputs all low while reset is held
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset outputs d%0d", i), int'(pack(i)), 0);

    // First cycle after reset: only MEM_LAT=1 fetch completes immediately
    @(posedge clk);
    #1 rst_v = 3'b000;
    @(negedge clk);
    chk("post-reset d0", int'(pack(0)), int'(18'h30000));
    chk("post-reset d1", int'(pack(1)), 0);
    chk("post-reset d2", int'(pack(2)), 0);
    @(negedge clk);
    chk("post-reset d1 fetch done", int'(pack(1)), int'(18'h30000));

    foreach (tbl[i]) run_vec(tbl[i], i);

    // sw at MEM_LAT=2 with reset asserted in the second MEM cycle
    op_v[1] = 6'h2b; func_v[1] = 6'h00;
    pulse_reset(1);
    mem_cnt = 0;
    while (state_v[1] != 3'd3 && mem_cnt < 20) begin
      @(negedge clk);
      #1 mem_cnt++;
    end
    chk("sw reached MEM", int'(state_v[1] == 3'd3), 1);
    chk("sw mem_we first MEM", int'(mem_we_v[1]), 1);
    @(posedge clk);
    #1 rst_v[1] = 1'b1;
    @(negedge clk);
    chk("sw mem_we under reset", int'(mem_we_v[1]), 0);
    chk("sw state under reset", int'(state_v[1]), 3);
    @(posedge clk);
    #1 rst_v[1] = 1'b0;
    @(negedge clk);
    chk("after abort outputs", int'(pack(1)), 0);
    @(negedge clk);
    chk("after abort fetch done", int'(pack(1)), int'(18'h30000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory access cycles per fetch/load/store (legal 1..15).
REQ-002 SHALL have parameter CNT_W, default 4, latency counter width; MEM_LAT shall fit in CNT_W bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports op and func  input  6 each  opcode and funct fields from the instruction register.
REQ-006 SHALL have port zero  input  1  ALU equality flag, sampled in EXEC.
REQ-007 SHALL have ports pc_we, ir_we, reg_we, mem_we, alusrc, memtoreg, illegal  output  1 each.
REQ-008 SHALL have ports aluop, extop, regdst, npc_sel  output  2 each; state  output  3  current state.

Function
REQ-009 SHALL implement a Moore/Mealy FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-010 FETCH SHALL last MEM_LAT cycles; its last cycle SHALL assert ir_we and pc_we with npc_sel=00 (PC+4), then go to DECODE.
REQ-011 DECODE SHALL last 1 cycle; legal instruction -> EXEC; illegal -> FETCH with illegal=1 for that cycle and no write enables.
REQ-012 Base legal set: addu, subu, ori, lw, sw, beq, lui, j, jal, jr (MIPS-I encodings).
REQ-013 EXEC SHALL last 1 cycle: addu/subu/ori/lui -> WB; lw/sw -> MEM; beq -> FETCH, pc_we=zero, npc_sel=01; j -> FETCH, pc_we=1, npc_sel=10; jr -> FETCH, pc_we=1, npc_sel=11; jal -> WB, pc_we=1, npc_sel=10.
REQ-014 MEM SHALL last MEM_LAT cycles; sw asserts mem_we every MEM cycle then -> FETCH; lw -> WB after last cycle.
REQ-015 WB SHALL last 1 cycle with reg_we=1, then -> FETCH.
REQ-016 Datapath selects SHALL be held constant from DECODE through end of instruction: aluop 00 add,01 sub,10 or/lui; extop 00 zero,01 sign,10 upper; regdst 00 rt,01 rd,10 r31; alusrc=1 for ori/lw/sw/lui; memtoreg=1 for lw.
REQ-017 Latency counter SHALL reset to 0 on entry to FETCH/MEM and on wrap; no state other than FETCH/MEM uses it.
REQ-018 Instruction cycle counts (MEM_LAT=L): R-type/ori/lui L+3; lw 2L+3; sw 2L+2; beq/j/jr L+2; jal L+3; illegal L+1.
REQ-019 All write enables (pc_we, ir_we, reg_we, mem_we) SHALL never be asserted in the same cycle as illegal.

Reset
REQ-020 reset=1 at any edge SHALL force state=FETCH, counter=0, abort the current instruction with no further write enables.
REQ-021 While in reset and the cycle after, all outputs SHALL be 0 except state=0 (FETCH) and ir_we/pc_we only when MEM_LAT cycles have elapsed.
REQ-022 reset SHALL take priority over every transition, including the last cycle of MEM for sw (mem_we deasserted).

Configuration
REQ-023 Macro MC_CTRL_EXT_EN defined: addiu (op 001001: aluop 00, alusrc 1, extop 01, regdst 00, -> WB) and bne (op 000101: pc_we=~zero, npc_sel=01) are legal.
REQ-024 MC_CTRL_EXT_EN undefined: addiu and bne SHALL be decoded illegal per REQ-011; no other behaviour changes.

Structure
REQ-025 Package mc_ctrl_pkg SHALL hold opcode/funct constants, state encoding, aluop/extop/regdst/npc_sel encodings.
REQ-026 Combinational instruction-class decode SHALL be sub-module mc_ctrl_dec; the FSM and counter stay in mc_ctrl.

Verification
REQ-027 MEM_LAT=1, addu (op 0, func 100001): FETCH,DECODE,EXEC,WB over 4 cycles; reg_we=1 only in WB, regdst=01.
REQ-028 MEM_LAT=3, lw (op 100011): 9 cycles; ir_we on cycle 3, reg_we on cycle 9, memtoreg=1, extop=01.
REQ-029 MEM_LAT=1, beq with zero=0 then zero=1: pc_we in EXEC 0 then 1, npc_sel=01, 3 cycles each.
REQ-030 MEM_LAT=2, sw with reset asserted in 2nd MEM cycle: mem_we 1 then 0, state=0 next cycle.
REQ-031 op 111111: illegal=1 in DECODE, no write enables, back to FETCH; op 000101 illegal only without MC_CTRL_EXT_EN.
REQ-032 jal at MEM_LAT=1: EXEC pc_we=1 npc_sel=10, WB reg_we=1 regdst=10, 4 cycles total.
